// File: rtl/jb_clk_en_prog_gen.sv
// Multi-channel programmable clock-enable generator. Each channel pulses once
// per (div+1) cycles at a programmable phase; new settings apply at period end.
module jb_clk_en_prog_gen #(
    parameter int NUM_CH = 4,
    parameter int DIV_W  = 8,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              sync,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic [DIV_W-1:0]  cfg_phase,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] clk_en,
    output logic [NUM_CH-1:0] cfg_pending
);

    // Handshake: a transfer happens in any cycle where cfg_valid & cfg_ready
    // are both high at the rising edge; cfg_ready never depends on cfg_valid.

    logic              run_r;
    logic [DIV_W-1:0]  cnt      [NUM_CH];
    logic [DIV_W-1:0]  div_act  [NUM_CH];
    logic [DIV_W-1:0]  ph_act   [NUM_CH];
    logic [DIV_W-1:0]  div_pend [NUM_CH];
    logic [DIV_W-1:0]  ph_pend  [NUM_CH];
    logic [NUM_CH-1:0] pend;

    logic [NUM_CH-1:0] sel;
    logic              ch_ok;
    logic              accept;
    logic [NUM_CH-1:0] wr;

    function automatic logic [DIV_W-1:0] clamp(input logic [DIV_W-1:0] ph,
                                               input logic [DIV_W-1:0] dv);
        return (ph > dv) ? dv : ph;
    endfunction

    // One-hot channel decode; an out-of-range cfg_ch selects nothing.
    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sel[i] = (cfg_ch == CH_W'(i));
        end
    end

    assign ch_ok       = |sel;
    assign cfg_ready   = ~|(sel & pend);
    assign accept      = cfg_valid & cfg_ready;
    assign wr          = sel & {NUM_CH{accept}};
    assign cfg_pending = pend;

    always_comb begin
        clk_en = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            clk_en[i] = run_r & (cnt[i] == ph_act[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            run_r   <= 1'b0;
            cfg_err <= 1'b0;
            pend    <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i]      <= '0;
                div_act[i]  <= '0;
                ph_act[i]   <= '0;
                div_pend[i] <= '0;
                ph_pend[i]  <= '0;
            end
        end else begin
            run_r   <= enable;
            cfg_err <= accept & ~ch_ok;
            for (int i = 0; i < NUM_CH; i++) begin
                if (sync) begin
                    // A write landing with sync bypasses the pending register.
                    cnt[i]  <= '0;
                    pend[i] <= 1'b0;
                    if (wr[i]) begin
                        div_act[i] <= cfg_div;
                        ph_act[i]  <= clamp(cfg_phase, cfg_div);
                    end else if (pend[i]) begin
                        div_act[i] <= div_pend[i];
                        ph_act[i]  <= clamp(ph_pend[i], div_pend[i]);
                    end
                end else begin
                    if (run_r) begin
                        if (cnt[i] == div_act[i]) begin
                            cnt[i] <= '0;
                            if (pend[i]) begin
                                div_act[i] <= div_pend[i];
                                ph_act[i]  <= clamp(ph_pend[i], div_pend[i]);
                                pend[i]    <= 1'b0;
                            end
                        end else begin
                            cnt[i] <= cnt[i] + 1'b1;
                        end
                    end
                    // wr and a pending boundary are exclusive: ready is low while pend.
                    if (wr[i]) begin
                        div_pend[i] <= cfg_div;
                        ph_pend[i]  <= cfg_phase;
                        pend[i]     <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_jb_clk_en_prog_gen.sv
// Randomised and directed bench for jb_clk_en_prog_gen against a cycle-count
// reference model (position in period = run cycles since last alignment mod period).
module tb_jb_clk_en_prog_gen;

    localparam int NUM_CH = 4;
    localparam int DIV_W  = 8;
    localparam int CH_W   = 3;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              enable;
    logic              sync;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [CH_W-1:0]   cfg_ch;
    logic [DIV_W-1:0]  cfg_div;
    logic [DIV_W-1:0]  cfg_phase;
    logic              cfg_err;
    logic [NUM_CH-1:0] clk_en;
    logic [NUM_CH-1:0] cfg_pending;

    int total = 0;
    int bad   = 0;

    // clock / reset
    always #5 clk = ~clk;

    jb_clk_en_prog_gen #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .CH_W(CH_W)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .sync(sync),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
        .cfg_div(cfg_div), .cfg_phase(cfg_phase), .cfg_err(cfg_err),
        .clk_en(clk_en), .cfg_pending(cfg_pending)
    );

    // reference model
    bit m_run;
    bit m_err;
    int m_k    [NUM_CH];
    int m_div  [NUM_CH];
    int m_ph   [NUM_CH];
    bit m_pend [NUM_CH];
    int m_pdiv [NUM_CH];
    int m_pph  [NUM_CH];

    function automatic bit model_ready(input int ch);
        if (ch >= NUM_CH) return 1'b1;
        return !m_pend[ch];
    endfunction

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    always @(posedge clk) begin
        if (!reset_n) begin
            m_run = 0;
            m_err = 0;
            for (int i = 0; i < NUM_CH; i++) begin
                m_k[i] = 0; m_div[i] = 0; m_ph[i] = 0; m_pend[i] = 0;
            end
        end else begin
            bit acc;
            int ch;
            ch    = int'(cfg_ch);
            acc   = cfg_valid && model_ready(ch);
            m_err = acc && (ch >= NUM_CH);
            for (int i = 0; i < NUM_CH; i++) begin
                bit w;
                w = acc && (ch == i);
                if (sync) begin
                    m_k[i] = 0;
                    if (w) begin
                        m_div[i] = int'(cfg_div);
                        m_ph[i]  = min_i(int'(cfg_phase), int'(cfg_div));
                    end else if (m_pend[i]) begin
                        m_div[i] = m_pdiv[i];
                        m_ph[i]  = min_i(m_pph[i], m_pdiv[i]);
                    end
                    m_pend[i] = 0;
                end else begin
                    if (m_run) begin
                        if (m_pend[i] && (m_k[i] % (m_div[i] + 1) == m_div[i])) begin
                            m_div[i]  = m_pdiv[i];
                            m_ph[i]   = min_i(m_pph[i], m_pdiv[i]);
                            m_k[i]    = 0;
                            m_pend[i] = 0;
                        end else begin
                            m_k[i] = m_k[i] + 1;
                        end
                    end
                    if (w) begin
                        m_pdiv[i] = int'(cfg_div);
                        m_pph[i]  = int'(cfg_phase);
                        m_pend[i] = 1;
                    end
                end
            end
            m_run = enable;
        end
    end

    // scoreboard
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%0h want=%0h", tag, $time, obs, exp);
        end
    endtask

    task automatic step();
        logic [NUM_CH-1:0] e_en;
        logic [NUM_CH-1:0] e_pend;
        @(negedge clk);
        e_en = '0;
        e_pend = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            e_en[i]   = m_run && ((m_k[i] % (m_div[i] + 1)) == m_ph[i]);
            e_pend[i] = m_pend[i];
        end
        check("clk_en",      32'(clk_en),      32'(e_en));
        check("cfg_pending", 32'(cfg_pending), 32'(e_pend));
        check("cfg_err",     32'(cfg_err),     32'(m_err));
        check("cfg_ready",   32'(cfg_ready),   32'(model_ready(int'(cfg_ch))));
    endtask

    // driver tasks
    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_cfg(input int ch, input int dv, input int ph);
        cfg_valid = 1'b1;
        cfg_ch    = CH_W'(ch);
        cfg_div   = DIV_W'(dv);
        cfg_phase = DIV_W'(ph);
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic pulse_sync();
        sync = 1'b1;
        step();
        sync = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; enable = 1'b1; sync = 1'b0;
        cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_phase = '0;
        run(3);
        check("reset_clk_en", 32'(clk_en), 32'h0);
        reset_n = 1'b1;
        run(2);
        check("run_all_ones", 32'(clk_en), 32'hf);
        run(4);

        // ch1 div=3 phase=2
        do_cfg(1, 3, 2);
        run(14);

        // ch2 period 8, then rewrite mid-period with a held second write
        do_cfg(2, 7, 0);
        run(12);
        run(3);
        do_cfg(2, 1, 1);
        cfg_valid = 1'b1; cfg_ch = 3'd2; cfg_div = 8'd5; cfg_phase = 8'd3;
        run(3);
        cfg_valid = 1'b0;
        run(20);

        // realign channels at div 2/4/6, with ch0 pending at sync
        do_cfg(0, 2, 1);
        do_cfg(1, 4, 0);
        do_cfg(2, 6, 5);
        run(16);
        do_cfg(0, 5, 2);
        pulse_sync();
        run(10);
        // accept and sync in the same cycle
        sync = 1'b1;
        do_cfg(3, 4, 4);
        sync = 1'b0;
        run(10);

        // out-of-range channel and phase clamp
        do_cfg(5, 1, 1);
        run(3);
        do_cfg(7, 2, 0);
        do_cfg(3, 3, 9);
        run(12);

        // enable drop mid-period
        run(2);
        enable = 1'b0;
        run(5);
        check("frozen_clk_en", 32'(clk_en), 32'h0);
        enable = 1'b1;
        run(10);

        // reset while pending
        do_cfg(2, 200, 100);
        run(2);
        reset_n = 1'b0;
        run(2);
        check("reset_pending", 32'(cfg_pending), 32'h0);
        reset_n = 1'b1;
        run(4);

        // randomised traffic
        for (int n = 0; n < 3000; n++) begin
            enable    = ($urandom_range(0, 15) != 0);
            sync      = ($urandom_range(0, 60) == 0);
            cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_ch    = CH_W'($urandom_range(0, 5));
            cfg_div   = ($urandom_range(0, 9) == 0) ? DIV_W'($urandom_range(0, 255))
                                                    : DIV_W'($urandom_range(0, 7));
            cfg_phase = DIV_W'($urandom_range(0, 9));
            if ($urandom_range(0, 999) == 0) reset_n = 1'b0;
            else reset_n = 1'b1;
            step();
        end
        cfg_valid = 1'b0; sync = 1'b0; reset_n = 1'b1;
        run(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/jb_clk_en_prog_gen.md
# jb_clk_en_prog_gen

Parametrised, multi-channel clock-enable generator for single-clock-domain datapaths. Each of NUM_CH channels emits a one-cycle enable pulse every (div+1) cycles at a programmable phase. Divide ratio and phase are reprogrammable at run time through a valid/ready interface, and a new setting takes effect only at that channel's period boundary, so no enable period is ever truncated. A global sync pulse realigns all channels to a common phase 0, and a global enable freezes every channel.

## Interface
- NUM_CH, 4: number of independent enable channels (≥1).
- DIV_W, 8: width of the divide and phase fields; maximum ratio 2^DIV_W.
- CH_W, $clog2(NUM_CH) min 1: width of the channel-select field.
- clk  in  1  single clock.
- reset_n  in  1  synchronous, active-low reset.
- enable  in  1  global run; registered internally as run_r.
- sync  in  1  one-cycle realign pulse.
- cfg_valid  in  1  configuration request.
- cfg_ready  out  1  configuration accept qualifier.
- cfg_ch  in  CH_W  target channel.
- cfg_div  in  DIV_W  divide ratio minus 1 (0 means every cycle).
- cfg_phase  in  DIV_W  counter value at which the pulse fires.
- cfg_err  out  1  one-cycle pulse when a request addresses a channel ≥ NUM_CH.
- clk_en  out  NUM_CH  per-channel enable pulses.
- cfg_pending  out  NUM_CH  per-channel flag: a setting is accepted but not yet applied.

## Operation
- Reset is synchronous and active-low: one clock, one reset_n, no other resets.
- Per-channel state:
  - cnt: DIV_W bits.
  - div_act, ph_act: the active setting.
  - div_pend, ph_pend: the pending setting.
  - pend: the pending flag.
- Reset values: cnt=0, div_act=0, ph_act=0, pend=0, run_r=0.
- Reset output values: clk_en=0, cfg_err=0, cfg_pending=0. cfg_ready reflects pend=0, so it is 1.
- run_r <= enable every cycle.
- Counter behaviour when run_r=1:
  - If cnt == div_act, cnt wraps to 0.
  - Otherwise cnt increments by 1.
  - When run_r=0, cnt holds.
- clk_en[i] = run_r & (cnt[i] == ph_act[i]). It is decoded from registered state only, with no input-to-output combinational path.
- Phase clamp: on load, ph_act = min(phase, div). A channel therefore always fires exactly once per period.
- Handshake:
  - cfg_ready = ~pend[cfg_ch] when cfg_ch < NUM_CH; cfg_ready = 1 otherwise.
  - A request is accepted when cfg_valid & cfg_ready.
  - On acceptance for a valid channel, the pending setting is captured into div_pend/ph_pend and pend is set.
  - On acceptance for cfg_ch ≥ NUM_CH, the request is discarded and cfg_err pulses the next cycle.
- Apply at boundary: in a cycle with run_r & pend & (cnt == div_act), the channel loads div_act/ph_act from pending, sets cnt=0 and clears pend.
- Sync: while sync=1, every channel sets cnt=0 and applies its pending setting immediately, if any, clearing pend. Sync acts regardless of run_r.
- Simultaneous events:
  - Accept and sync on the same channel in the same cycle: the newly written setting is applied immediately.
  - Accept and boundary on the same channel in the same cycle: cannot occur, because ready is low while pend=1. An accept in the wrap cycle of a channel with pend=0 applies at the following boundary.
  - enable falls while pend=1: the setting stays pending until run resumes and the boundary is reached, or until a sync.
- Reset mid-operation: all state returns to reset values and any pending setting is discarded.

## Timing
- enable sampled 1 at edge k: run_r=1 from cycle k+1. With default settings, clk_en is all-ones from cycle k+1.
- Period per channel: div_act+1 cycles. The pulse is 1 cycle wide, or continuous when div_act=0.
- Accept at edge t:
  - cfg_pending[ch]=1 from cycle t+1.
  - The new setting governs from the cycle after the first cycle ≥ t+1 in which cnt == div_act with run_r=1.
  - The boundary cycle itself still uses the old ph_act.
- Sync sampled at edge s: cnt=0 for all channels in cycle s+1. A channel with ph_act=0 pulses in s+1 if run_r=1.
- cfg_err: asserted in the cycle after the rejected accept, for exactly 1 cycle.
- cfg_ready is combinational from cfg_ch and registered pend. It goes high the cycle after pend clears.

## Test plan
- Reset release with enable=1 → clk_en=4'b1111 every cycle. cfg_pending=0 and cfg_ready=1 during and after reset.
- Program ch1 div=3 phase=2, then hold → after the apply, clk_en[1] is high when cnt=2, every 4 cycles. The other channels are unaffected.
- With ch2 at div=7, write div=1 mid-period → the old 8-cycle period completes intact, then the channel runs a 2-cycle period. cfg_ready for ch2 is low throughout the pending interval, and a second write is held off.
- Channels at div=2/4/6, assert sync → all cnt are 0 the next cycle, and pulses are realigned according to each ph_act. A pending write on ch0 is applied at the sync, not at its boundary.
- cfg_ch=5 with NUM_CH=4 → request accepted, cfg_err pulses for 1 cycle, no channel state changes. Also write phase=9 with div=3 → ph_act clamps to 3.
- Drop enable for 5 cycles mid-period → clk_en=0 and counters hold, then resume from the held value. Assert reset_n=0 while pend=1 → all outputs and state return to reset values.
